// File: rtl/ex_mem_skid_pkg.sv
// Shared constants and state encoding for the EX->MEM skid boundary.
package ex_mem_skid_pkg;

    localparam logic        RST_ENABLE   = 1'b1;
    localparam int unsigned REG_BUS      = 32;
    localparam int unsigned REG_ADDR_BUS = 5;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

    // Occupancy of the boundary: nothing, head only, head plus skid.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_HEAD  = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/ex_mem_skid_slot.sv
// One payload slot (waddr, we, wdata) with a load enable; cleared only by reset.
module ex_mem_skid_slot
    import ex_mem_skid_pkg::*;
#(
    parameter int unsigned DATA_W = REG_BUS,
    parameter int unsigned ADDR_W = REG_ADDR_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [ADDR_W-1:0] waddr_o,
    output logic              we_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic [ADDR_W-1:0] r_waddr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;

    // Payload register: reset to zero, otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_waddr <= '0;
            r_we    <= 1'b0;
            r_wdata <= DATA_W'(ZERO_WORD);
        end else if (load_i) begin
            r_waddr <= waddr_i;
            r_we    <= we_i;
            r_wdata <= wdata_i;
        end
    end

    assign waddr_o = r_waddr;
    assign we_o    = r_we;
    assign wdata_o = r_wdata;

endmodule

// File: rtl/ex_mem_skid.sv
// Registered EX->MEM boundary: valid/ready handshake with a head slot and one skid slot.
// ready_o is a flop derived from next state, so MEM stalls never reach EX combinationally.
module ex_mem_skid
    import ex_mem_skid_pkg::*;
#(
    parameter int unsigned DATA_W = REG_BUS,
    parameter int unsigned ADDR_W = REG_ADDR_BUS,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] waddr_o,
    output logic              we_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              fwd_we_o,
    output logic [ADDR_W-1:0] fwd_waddr_o,
    output logic [DATA_W-1:0] fwd_wdata_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    skid_state_e r_state;
    skid_state_e w_state_nxt;
    logic        r_ready;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_accept;
    logic w_pop;
    logic w_head_valid;
    logic w_head_load;
    logic w_head_from_skid;
    logic w_skid_load;

    logic [ADDR_W-1:0] w_head_waddr_in;
    logic              w_head_we_in;
    logic [DATA_W-1:0] w_head_wdata_in;

    logic [ADDR_W-1:0] w_head_waddr;
    logic              w_head_we;
    logic [DATA_W-1:0] w_head_wdata;
    logic [ADDR_W-1:0] w_skid_waddr;
    logic              w_skid_we;
    logic [DATA_W-1:0] w_skid_wdata;

    assign w_head_valid = (r_state != SKID_EMPTY);
    assign w_accept     = valid_i & r_ready;
    assign w_pop        = w_head_valid & ready_i;

    // Next-state and slot load decisions; flush wins over accept and pop.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_load      = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (flush_i) begin
            w_state_nxt = SKID_EMPTY;
        end else begin
            unique case (r_state)
                SKID_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = SKID_HEAD;
                        w_head_load = 1'b1;
                    end
                end
                SKID_HEAD: begin
                    if (w_accept && w_pop) begin
                        w_head_load = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = SKID_FULL;
                        w_skid_load = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    // ready_o is low here, so no accept can coincide with the pop.
                    if (w_pop) begin
                        w_state_nxt      = SKID_HEAD;
                        w_head_load      = 1'b1;
                        w_head_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = SKID_EMPTY;
                end
            endcase
        end
    end

    // Head input mux: refill from skid when draining FULL, else take EX directly.
    always_comb begin
        w_head_waddr_in = waddr_i;
        w_head_we_in    = we_i;
        w_head_wdata_in = wdata_i;
        if (w_head_from_skid) begin
            w_head_waddr_in = w_skid_waddr;
            w_head_we_in    = w_skid_we;
            w_head_wdata_in = w_skid_wdata;
        end
    end

    // State register and registered ready toward EX.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= SKID_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != SKID_FULL);
        end
    end

    // Saturating count of cycles where MEM holds off a valid head; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_stall_cnt <= '0;
        end else if (w_head_valid && !ready_i && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    ex_mem_skid_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_head_load),
        .waddr_i (w_head_waddr_in),
        .we_i    (w_head_we_in),
        .wdata_i (w_head_wdata_in),
        .waddr_o (w_head_waddr),
        .we_o    (w_head_we),
        .wdata_o (w_head_wdata)
    );

    ex_mem_skid_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_skid_load),
        .waddr_i (waddr_i),
        .we_i    (we_i),
        .wdata_i (wdata_i),
        .waddr_o (w_skid_waddr),
        .we_o    (w_skid_we),
        .wdata_o (w_skid_wdata)
    );

    assign ready_o     = r_ready;
    assign valid_o     = w_head_valid;
    assign waddr_o     = w_head_waddr;
    assign we_o        = w_head_valid & w_head_we;
    assign wdata_o     = w_head_wdata;
    assign fwd_we_o    = w_head_valid & w_head_we;
    assign fwd_waddr_o = w_head_waddr;
    assign fwd_wdata_o = w_head_wdata;
    assign stall_cnt_o = r_stall_cnt;

endmodule
